// File: rtl/agu_mem_req_pkg.sv
// Shared constants for the AGU load/store command path: access size codes,
// RV32 load/store funct3 codes, FSM state encoding and the legality check.
package agu_mem_req_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WBCK = 2'b10
  } state_e;

  // Only the RV32I load/store widths are accepted; anything else faults locally.
  function automatic logic ls_legal(input logic load, input logic store,
                                    input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (load)
      ok = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
           (funct3 == F3_LBU) || (funct3 == F3_LHU);
    else if (store)
      ok = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    return ok;
  endfunction

endpackage

// File: rtl/agu_ls_align.sv
// Combinational store alignment: byte enables, lane-replicated write data and
// the misalignment flag from the low address bits and the access size.
module agu_ls_align
  import agu_mem_req_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  output logic              misalgn
);

  localparam logic [XLEN/8-1:0] MASK_B = {{(XLEN/8-1){1'b0}}, 1'b1};
  localparam logic [XLEN/8-1:0] MASK_H = {{(XLEN/8-2){1'b0}}, 2'b11};

  // Half-word masks snap to the even lane pair so a misaligned half still
  // produces a well-formed enable pattern; the memory unit raises the fault.
  always_comb begin
    wmask   = '0;
    wdata   = '0;
    misalgn = 1'b0;
    case (size)
      SIZE_B: begin
        wmask = MASK_B << addr_lo;
        wdata = {(XLEN/8){rs2[7:0]}};
      end
      SIZE_H: begin
        wmask   = MASK_H << {addr_lo[1], 1'b0};
        wdata   = {(XLEN/16){rs2[15:0]}};
        misalgn = addr_lo[0];
      end
      SIZE_W: begin
        wmask   = '1;
        wdata   = rs2;
        misalgn = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/agu_mem_req.sv
// AGU load/store initiator: accepts one EXU load/store, issues it to the memory
// unit, waits (bounded) for completion and hands the result to writeback.
module agu_mem_req
  import agu_mem_req_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PC_SIZE     = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exu_i_valid,
  output logic               exu_o_ready,
  input  logic               exu_i_load,
  input  logic               exu_i_store,
  input  logic [2:0]         exu_i_funct3,
  input  logic [XLEN-1:0]    exu_i_rs1,
  input  logic [XLEN-1:0]    exu_i_imm,
  input  logic [XLEN-1:0]    exu_i_rs2,
  input  logic [4:0]         exu_i_rd,
  output logic               agu_o_cmd_enable,
  output logic               agu_o_cmd_read,
  output logic               agu_o_cmd_write,
  output logic               agu_o_cmd_usign,
  output logic [1:0]         agu_o_cmd_size,
  output logic [PC_SIZE-1:0] agu_o_cmd_addr,
  output logic [XLEN-1:0]    agu_o_cmd_wdata,
  output logic [XLEN/8-1:0]  agu_o_cmd_wmask,
  output logic               agu_o_cmd_misalgn,
  input  logic [XLEN-1:0]    memtop_i_wdata,
  input  logic               memtop_i_err,
  input  logic               memtop_i_ready,
  output logic               wbck_o_valid,
  input  logic               wbck_i_ready,
  output logic               wbck_o_we,
  output logic [4:0]         wbck_o_rd,
  output logic [XLEN-1:0]    wbck_o_wdata,
  output logic               wbck_o_err,
  output logic [PC_SIZE-1:0] wbck_o_badaddr
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [PC_SIZE-1:0]   addr_q;
  logic [4:0]           rd_q;
  logic                 load_q, store_q;
  logic [2:0]           funct3_q;
  logic [XLEN-1:0]      rs2_q;
  logic [XLEN-1:0]      res_wdata_q;
  logic                 res_err_q;

  logic                 accept, in_req, in_wbck, legal_in, timeout_hit;
  logic [7:0]           cnt_inc;
  logic [XLEN-1:0]      addr_sum;
  logic [XLEN/8-1:0]    al_wmask;
  logic [XLEN-1:0]      al_wdata;
  logic                 al_misalgn;

  assign in_req      = (state_q == ST_REQ);
  assign in_wbck     = (state_q == ST_WBCK);
  assign exu_o_ready = (state_q == ST_IDLE);
  assign accept      = exu_i_valid & exu_o_ready;
  assign legal_in    = ls_legal(exu_i_load, exu_i_store, exu_i_funct3);
  assign addr_sum    = exu_i_rs1 + exu_i_imm;
  assign cnt_inc     = cnt_q + 8'd1;
  assign timeout_hit = in_req & ~memtop_i_ready & (cnt_inc == TIMEOUT_LIM);

  agu_ls_align #(.XLEN(XLEN)) u_align (
    .addr_lo (addr_q[1:0]),
    .size    (funct3_q[1:0]),
    .rs2     (rs2_q),
    .wmask   (al_wmask),
    .wdata   (al_wdata),
    .misalgn (al_misalgn)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Illegal encodings skip REQ entirely; ready beats a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = legal_in ? ST_REQ : ST_WBCK;
      end
      ST_REQ: begin
        if (memtop_i_ready || timeout_hit) begin
          state_d = ST_WBCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WBCK: begin
        if (wbck_i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture at accept and result capture when REQ completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      rd_q        <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      rs2_q       <= '0;
      res_wdata_q <= '0;
      res_err_q   <= 1'b0;
    end else if (accept) begin
      addr_q      <= addr_sum[PC_SIZE-1:0];
      rd_q        <= exu_i_rd;
      load_q      <= exu_i_load;
      store_q     <= exu_i_store;
      funct3_q    <= exu_i_funct3;
      rs2_q       <= exu_i_rs2;
      res_wdata_q <= '0;
      res_err_q   <= ~legal_in;
    end else if (in_req && memtop_i_ready) begin
      res_wdata_q <= memtop_i_wdata;
      res_err_q   <= memtop_i_err | al_misalgn;
    end else if (timeout_hit) begin
      res_wdata_q <= '0;
      res_err_q   <= 1'b1;
    end
  end

  assign agu_o_cmd_enable  = in_req;
  assign agu_o_cmd_read    = in_req & load_q;
  assign agu_o_cmd_write   = in_req & store_q;
  assign agu_o_cmd_usign   = in_req & funct3_q[2];
  assign agu_o_cmd_size    = in_req ? funct3_q[1:0] : 2'b00;
  assign agu_o_cmd_addr    = in_req ? addr_q : '0;
  assign agu_o_cmd_wdata   = (in_req & store_q) ? al_wdata : '0;
  assign agu_o_cmd_wmask   = (in_req & store_q) ? al_wmask : '0;
  assign agu_o_cmd_misalgn = in_req & al_misalgn;

  assign wbck_o_valid   = in_wbck;
  assign wbck_o_we      = in_wbck & load_q & ~res_err_q;
  assign wbck_o_rd      = in_wbck ? rd_q : 5'd0;
  assign wbck_o_wdata   = in_wbck ? res_wdata_q : '0;
  assign wbck_o_err     = in_wbck & res_err_q;
  assign wbck_o_badaddr = in_wbck ? addr_q : '0;

endmodule

// File: tb/tb_agu_mem_req.sv
// Randomized self-checking bench for agu_mem_req against a byte-lane level
// reference model of the load/store command and writeback behaviour.
module tb_agu_mem_req;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_i_valid, exu_o_ready, exu_i_load, exu_i_store;
  logic [2:0]  exu_i_funct3;
  logic [31:0] exu_i_rs1, exu_i_imm, exu_i_rs2;
  logic [4:0]  exu_i_rd;
  logic        agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_usign;
  logic [1:0]  agu_o_cmd_size;
  logic [31:0] agu_o_cmd_addr, agu_o_cmd_wdata;
  logic [3:0]  agu_o_cmd_wmask;
  logic        agu_o_cmd_misalgn;
  logic [31:0] memtop_i_wdata;
  logic        memtop_i_err, memtop_i_ready;
  logic        wbck_o_valid, wbck_i_ready, wbck_o_we, wbck_o_err;
  logic [4:0]  wbck_o_rd;
  logic [31:0] wbck_o_wdata, wbck_o_badaddr;

  int total = 0;
  int bad   = 0;

  agu_mem_req #(.XLEN(32), .PC_SIZE(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .exu_i_valid(exu_i_valid), .exu_o_ready(exu_o_ready),
    .exu_i_load(exu_i_load), .exu_i_store(exu_i_store),
    .exu_i_funct3(exu_i_funct3), .exu_i_rs1(exu_i_rs1), .exu_i_imm(exu_i_imm),
    .exu_i_rs2(exu_i_rs2), .exu_i_rd(exu_i_rd),
    .agu_o_cmd_enable(agu_o_cmd_enable), .agu_o_cmd_read(agu_o_cmd_read),
    .agu_o_cmd_write(agu_o_cmd_write), .agu_o_cmd_usign(agu_o_cmd_usign),
    .agu_o_cmd_size(agu_o_cmd_size), .agu_o_cmd_addr(agu_o_cmd_addr),
    .agu_o_cmd_wdata(agu_o_cmd_wdata), .agu_o_cmd_wmask(agu_o_cmd_wmask),
    .agu_o_cmd_misalgn(agu_o_cmd_misalgn),
    .memtop_i_wdata(memtop_i_wdata), .memtop_i_err(memtop_i_err),
    .memtop_i_ready(memtop_i_ready),
    .wbck_o_valid(wbck_o_valid), .wbck_i_ready(wbck_i_ready),
    .wbck_o_we(wbck_o_we), .wbck_o_rd(wbck_o_rd), .wbck_o_wdata(wbck_o_wdata),
    .wbck_o_err(wbck_o_err), .wbck_o_badaddr(wbck_o_badaddr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: lanes covered by the access start at the address rounded down to
  // the access size; each enabled lane carries rs2's byte for that position.
  function automatic void refModel(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] rs1, input logic [31:0] imm,
                                   input logic [31:0] rs2,
                                   output bit legal, output logic [31:0] addr,
                                   output logic [3:0] mask, output logic [31:0] wdata,
                                   output bit mis);
    int nb, off, base;
    addr  = rs1 + imm;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    nb    = 1 << f3[1:0];
    off   = int'(addr % 4);
    base  = off - (off % nb);
    mis   = (addr % nb) != 0;
    mask  = '0;
    wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= base && i < base + nb) mask[i] = 1'b1;
      if (st) wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
    end
  endfunction

  task automatic applyStimulus(input bit ld, input logic [2:0] f3, input logic [31:0] rs1,
                               input logic [31:0] imm, input logic [31:0] rs2,
                               input logic [4:0] rd, input int rdy_dly,
                               input logic [31:0] mem_data, input bit mem_err,
                               input int stall);
    bit          legal, mis, timed_out, exp_err, exp_we;
    logic [31:0] addr, wd, exp_wd;
    logic [3:0]  mk;
    refModel(ld, !ld, f3, rs1, imm, rs2, legal, addr, mk, wd, mis);
    timed_out = legal && (rdy_dly >= TO);
    exp_err   = !legal || timed_out || mem_err || mis;
    exp_wd    = (!legal || timed_out) ? 32'd0 : mem_data;
    exp_we    = ld && !exp_err;

    @(negedge clk);
    checkOutput("exu_ready_idle", exu_o_ready, 1);
    exu_i_valid = 1'b1; exu_i_load = ld; exu_i_store = !ld; exu_i_funct3 = f3;
    exu_i_rs1 = rs1; exu_i_imm = imm; exu_i_rs2 = rs2; exu_i_rd = rd;
    @(negedge clk);
    exu_i_valid = 1'b0;

    if (legal) begin
      for (int k = 0; k < TO; k++) begin
        checkOutput("cmd_enable", agu_o_cmd_enable, 1);
        checkOutput("cmd_read", agu_o_cmd_read, ld);
        checkOutput("cmd_write", agu_o_cmd_write, !ld);
        checkOutput("cmd_usign", agu_o_cmd_usign, f3[2]);
        checkOutput("cmd_size", agu_o_cmd_size, f3[1:0]);
        checkOutput("cmd_addr", agu_o_cmd_addr, addr);
        checkOutput("cmd_wmask", agu_o_cmd_wmask, mk);
        checkOutput("cmd_wdata", agu_o_cmd_wdata, wd);
        checkOutput("cmd_misalgn", agu_o_cmd_misalgn, mis);
        checkOutput("exu_ready_req", exu_o_ready, 0);
        if (k == rdy_dly) begin
          memtop_i_ready = 1'b1; memtop_i_wdata = mem_data; memtop_i_err = mem_err;
        end else begin
          memtop_i_ready = 1'b0; memtop_i_wdata = $urandom; memtop_i_err = 1'($urandom);
        end
        @(negedge clk);
        memtop_i_ready = 1'b0;
        if (k == rdy_dly) break;
      end
    end

    for (int s = 0; s <= stall; s++) begin
      checkOutput("wbck_valid", wbck_o_valid, 1);
      checkOutput("wbck_we", wbck_o_we, exp_we);
      checkOutput("wbck_rd", wbck_o_rd, rd);
      checkOutput("wbck_wdata", wbck_o_wdata, exp_wd);
      checkOutput("wbck_err", wbck_o_err, exp_err);
      checkOutput("wbck_badaddr", wbck_o_badaddr, addr);
      checkOutput("wbck_cmd_off", agu_o_cmd_enable, 0);
      checkOutput("exu_ready_wbck", exu_o_ready, 0);
      if (s == stall) begin
        wbck_i_ready = 1'b1; exu_i_valid = 1'b0; memtop_i_ready = 1'b0;
      end else begin
        wbck_i_ready = 1'b0; exu_i_valid = 1'b1;
        memtop_i_ready = 1'b1; memtop_i_wdata = $urandom; memtop_i_err = 1'($urandom);
      end
      @(negedge clk);
    end
    wbck_i_ready = 1'b0; memtop_i_ready = 1'b0; exu_i_valid = 1'b0;
    checkOutput("wbck_done", wbck_o_valid, 0);
    checkOutput("cmd_idle", agu_o_cmd_enable, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; exu_i_valid = 1'b0; exu_i_load = 1'b0; exu_i_store = 1'b0;
    exu_i_funct3 = '0; exu_i_rs1 = '0; exu_i_imm = '0; exu_i_rs2 = '0; exu_i_rd = '0;
    memtop_i_wdata = '0; memtop_i_err = 1'b0; memtop_i_ready = 1'b0; wbck_i_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_exu_ready", exu_o_ready, 1);
    checkOutput("rst_cmd_enable", agu_o_cmd_enable, 0);
    checkOutput("rst_cmd_read", agu_o_cmd_read, 0);
    checkOutput("rst_cmd_write", agu_o_cmd_write, 0);
    checkOutput("rst_cmd_addr", agu_o_cmd_addr, 0);
    checkOutput("rst_cmd_wmask", agu_o_cmd_wmask, 0);
    checkOutput("rst_wbck_valid", wbck_o_valid, 0);
    checkOutput("rst_wbck_err", wbck_o_err, 0);
    checkOutput("rst_wbck_badaddr", wbck_o_badaddr, 0);
    rst = 1'b0;

    $display("[TB] directed: LW, SB, misaligned SH, illegal, timeout, stall");
    applyStimulus(1, 3'b010, 32'h100, 32'd4, 32'h0, 5'd7, 0, 32'hDEADBEEF, 0, 0);
    applyStimulus(0, 3'b000, 32'h203, 32'd0, 32'h12345678, 5'd3, 1, 32'h0, 0, 0);
    applyStimulus(0, 3'b001, 32'h300, 32'd1, 32'hCAFEF00D, 5'd0, 0, 32'h0, 1, 0);
    applyStimulus(1, 3'b011, 32'h400, 32'd8, 32'h0, 5'd9, 0, 32'h5555AAAA, 0, 0);
    applyStimulus(1, 3'b010, 32'h500, 32'd0, 32'h0, 5'd11, 100, 32'h11112222, 0, 0);
    applyStimulus(1, 3'b100, 32'h600, 32'd3, 32'h0, 5'd12, TO - 1, 32'h000000AB, 0, 0);
    applyStimulus(1, 3'b101, 32'h702, 32'd0, 32'h0, 5'd13, 2, 32'h0000BEEF, 0, 5);
    applyStimulus(0, 3'b010, 32'hFFFFFFFC, 32'd8, 32'h89ABCDEF, 5'd1, 0, 32'h0, 0, 1);

    $display("[TB] random transactions");
    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    5'($urandom), $urandom_range(0, TO + 1), $urandom,
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("[TB] reset during REQ");
    @(negedge clk);
    exu_i_valid = 1'b1; exu_i_load = 1'b1; exu_i_store = 1'b0; exu_i_funct3 = 3'b010;
    exu_i_rs1 = 32'h800; exu_i_imm = 32'd0;
    @(negedge clk);
    exu_i_valid = 1'b0;
    checkOutput("pre_rst_enable", agu_o_cmd_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_enable", agu_o_cmd_enable, 0);
    checkOutput("mid_rst_valid", wbck_o_valid, 0);
    checkOutput("mid_rst_exu_ready", exu_o_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_exu_ready", exu_o_ready, 1);
    checkOutput("post_rst_enable", agu_o_cmd_enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
